// File: rtl/bit_pixel_bram_reader_if.sv
// Bit-pixel BRAM reader bus: the BRAM read port and the three-third pixel stream.
interface bit_pixel_bram_reader_if;
    logic [18:0] bram_rd_addr;
    logic        bram_rd_en;
    logic [1:0]  bram_q;
    logic [5:0]  pix_out;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;

    modport master (
        output bram_rd_addr, bram_rd_en, pix_out, pix_valid, pix_sof, pix_eol, pix_eof,
        input  bram_q, pix_ready
    );

    modport slave (
        input  bram_rd_addr, bram_rd_en, pix_out, pix_valid, pix_sof, pix_eol, pix_eof,
        output bram_q, pix_ready
    );
endinterface

// File: rtl/bit_pixel_bram_reader.sv
// Reads each completed bit-pixel image row-major from its BRAM buffer set and streams the three thirds'
// words per (row,col). Optional macro BIT_PIX_RD_STALL_CNT_EN adds a saturating stall counter output.
module bit_pixel_bram_reader #(
    parameter int THIRD_COLS = 240,
    parameter int THIRD_ROWS = 480,
    parameter int RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  image_number_i,
    output logic        busy_o,
    output logic [3:0]  rd_image_number_o,
    output logic        overrun_o,
`ifdef BIT_PIX_RD_STALL_CNT_EN
    output logic [15:0] stall_cnt_o,
`endif
    bit_pixel_bram_reader_if.master bus
);

    localparam int         WR_COLS  = THIRD_COLS / 2;
    localparam logic [6:0] COL_LAST = 7'(WR_COLS - 1);
    localparam logic [8:0] ROW_LAST = 9'(THIRD_ROWS - 1);
    localparam logic [15:0] ROW_STEP = 16'(WR_COLS);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_OUT} state_t;

    state_t      state_q, state_d;
    logic [8:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [15:0] row_base_q, row_base_d;
    logic [1:0]  third_q, third_d;
    logic        buf_q, buf_d;
    logic [3:0]  rd_img_q, rd_img_d;
    logic        overrun_q, overrun_d;

    logic [RD_LAT-1:0] tag_vld_q;
    logic [1:0]        tag_third_q [RD_LAT];
    logic [1:0]        slot_q [3];

    logic       issue;
    logic       out_vld;
    logic       at_eol;
    logic       at_last_row;
    logic       cap_vld;
    logic [1:0] cap_third;
    logic [3:0] img_gap;

    assign issue       = (state_q == ST_ISSUE);
    assign out_vld     = (state_q == ST_OUT);
    assign at_eol      = (col_q == COL_LAST);
    assign at_last_row = (row_q == ROW_LAST);
    assign cap_vld     = tag_vld_q[RD_LAT-1];
    assign cap_third   = tag_third_q[RD_LAT-1];
    assign img_gap     = image_number_i - rd_img_q;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        third_d    = third_q;
        buf_d      = buf_q;
        rd_img_d   = rd_img_q;
        overrun_d  = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (img_gap != 4'd0) begin
                    state_d    = ST_ISSUE;
                    row_d      = 9'd0;
                    col_d      = 7'd0;
                    row_base_d = 16'd0;
                    third_d    = 2'd0;
                    if (img_gap >= 4'd2) overrun_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (third_q == 2'd2) begin
                    third_d = 2'd0;
                    state_d = ST_WAIT;
                end else begin
                    third_d = third_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (cap_vld && (cap_third == 2'd2)) state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.pix_ready) begin
                    if (!at_eol) begin
                        col_d   = col_q + 7'd1;
                        state_d = ST_ISSUE;
                    end else if (!at_last_row) begin
                        col_d      = 7'd0;
                        row_d      = row_q + 9'd1;
                        row_base_d = row_base_q + ROW_STEP;
                        state_d    = ST_ISSUE;
                    end else begin
                        rd_img_d = rd_img_q + 4'd1;
                        buf_d    = ~buf_q;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= 9'd0;
            col_q      <= 7'd0;
            row_base_q <= 16'd0;
            third_q    <= 2'd0;
            buf_q      <= 1'b0;
            rd_img_q   <= 4'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            third_q    <= third_d;
            buf_q      <= buf_d;
            rd_img_q   <= rd_img_d;
            overrun_q  <= overrun_d;
        end
    end

    // Read-tag pipeline: tag of third t reaches the last stage exactly when its bram_q is valid
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q[0] <= issue;
            for (int k = 1; k < RD_LAT; k++) tag_vld_q[k] <= tag_vld_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_third_q[0] <= third_q;
        for (int k = 1; k < RD_LAT; k++) tag_third_q[k] <= tag_third_q[k-1];
        if (cap_vld) slot_q[cap_third] <= bus.bram_q;
    end

    assign bus.bram_rd_en   = issue;
    assign bus.bram_rd_addr = issue ? {buf_q, third_q, row_base_q + {9'd0, col_q}} : 19'd0;

    // Output stage: data slots are not reset, so everything is gated by the ST_OUT valid
    assign bus.pix_valid = out_vld;
    assign bus.pix_out   = out_vld ? {slot_q[2], slot_q[1], slot_q[0]} : 6'd0;
    assign bus.pix_sof   = out_vld && (row_q == 9'd0) && (col_q == 7'd0);
    assign bus.pix_eol   = out_vld && at_eol;
    assign bus.pix_eof   = out_vld && at_eol && at_last_row;

    assign busy_o            = (state_q != ST_IDLE);
    assign rd_image_number_o = rd_img_q;
    assign overrun_o         = overrun_q;

`ifdef BIT_PIX_RD_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (bus.pix_valid && bus.pix_ready && bus.pix_sof) begin
            stall_q <= 16'd0;
        end else if (bus.pix_valid && !bus.pix_ready) begin
            stall_q <= sat_inc16(stall_q);
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_bit_pixel_bram_reader.sv
// Scoreboard bench for bit_pixel_bram_reader on a reduced image geometry with a latency-modelled BRAM.
module tb_bit_pixel_bram_reader;
    localparam int THIRD_COLS = 8;
    localparam int THIRD_ROWS = 6;
    localparam int RD_LAT     = 2;
    localparam int WR_COLS    = THIRD_COLS / 2;
    localparam int BEATS      = WR_COLS * THIRD_ROWS;

    typedef struct packed {
        logic [5:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] image_number = 4'd0;
    logic       busy;
    logic       overrun;
    logic [3:0] rd_image_number;
`ifdef BIT_PIX_RD_STALL_CNT_EN
    logic [15:0] stall_cnt;
    int          stall_m = 0;
`endif

    bit_pixel_bram_reader_if bus();

    bit_pixel_bram_reader #(
        .THIRD_COLS(THIRD_COLS),
        .THIRD_ROWS(THIRD_ROWS),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .image_number_i   (image_number),
        .busy_o           (busy),
        .rd_image_number_o(rd_image_number),
        .overrun_o        (overrun),
`ifdef BIT_PIX_RD_STALL_CNT_EN
        .stall_cnt_o      (stall_cnt),
`endif
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int issued   = 0;
    int sof_seen = 0;
    int eof_seen = 0;
    int beat_cnt = 0;
    int sof_cyc  = 0;
    int eof_cyc  = 0;
    int low_pct  = 0;

    beat_t       exp_q[$];
    logic [18:0] addr_q[$];
    logic [1:0]  mem [2][3][BEATS];
    logic [1:0]  q_pipe [RD_LAT];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data appears on bram_q RD_LAT clocks after the read strobe
    function automatic logic [1:0] mem_rd(input logic [18:0] a);
        if (a[17:16] == 2'd3 || int'(a[15:0]) >= BEATS) return 2'd0;
        return mem[int'(a[18])][int'(a[17:16])][int'(a[15:0])];
    endfunction

    always @(posedge clk) begin
        q_pipe[0] <= bus.bram_rd_en ? mem_rd(bus.bram_rd_addr) : 2'd0;
        for (int k = 1; k < RD_LAT; k++) q_pipe[k] <= q_pipe[k-1];
    end
    assign bus.bram_q = q_pipe[RD_LAT-1];

    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.pix_ready = ($urandom_range(0, 99) >= low_pct);
        end
    end

    // Monitor: address scoreboard, beat scoreboard and hold-while-stalled checks
    initial begin
        beat_t cur;
        beat_t held;
        beat_t e;
        logic  hold_pend;
        logic [18:0] ea;
        hold_pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pend = 1'b0;
            end else begin
                if (bus.bram_rd_en) begin
                    if (addr_q.size() == 0) check("addr_unexpected", 1, 0);
                    else begin
                        ea = addr_q.pop_front();
                        check("rd_addr", bus.bram_rd_addr, ea);
                    end
                end
                cur = {bus.pix_out, bus.pix_sof, bus.pix_eol, bus.pix_eof};
                if (bus.pix_valid) begin
                    if (hold_pend) check("hold_stable", cur, held);
                    if (bus.pix_ready) begin
                        if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                        else begin
                            e = exp_q.pop_front();
                            check("pix_out", cur.pix, e.pix);
                            check("markers", {cur.sof, cur.eol, cur.eof}, {e.sof, e.eol, e.eof});
                        end
                        beat_cnt++;
                        if (cur.sof) begin sof_seen++; sof_cyc = cyc; end
                        if (cur.eof) begin
                            eof_seen++;
                            eof_cyc = cyc;
`ifdef BIT_PIX_RD_STALL_CNT_EN
                            check("stall_cnt", stall_cnt, 32'(stall_m));
`endif
                        end
`ifdef BIT_PIX_RD_STALL_CNT_EN
                        if (cur.sof) stall_m = 0;
`endif
                        hold_pend = 1'b0;
                    end else begin
`ifdef BIT_PIX_RD_STALL_CNT_EN
                        stall_m++;
`endif
                        hold_pend = 1'b1;
                        held = cur;
                    end
                end else begin
                    if (hold_pend) check("hold_valid", 0, 1);
                    hold_pend = 1'b0;
                end
            end
        end
    end

    task automatic fill_buf(input int b);
        for (int t = 0; t < 3; t++)
            for (int w = 0; w < BEATS; w++) mem[b][t][w] = 2'($urandom_range(0, 3));
    endtask

    task automatic push_image(input int b);
        beat_t e;
        for (int r = 0; r < THIRD_ROWS; r++) begin
            for (int c = 0; c < WR_COLS; c++) begin
                int w = r * WR_COLS + c;
                for (int t = 0; t < 3; t++) addr_q.push_back({1'(b), 2'(t), 16'(w)});
                e.pix = {mem[b][2][w], mem[b][1][w], mem[b][0][w]};
                e.sof = (w == 0);
                e.eol = (c == WR_COLS - 1);
                e.eof = (c == WR_COLS - 1) && (r == THIRD_ROWS - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Writer model: refills a buffer only once the reader has started on the image before it
    task automatic issue_image();
        int n = 0;
        int b;
        while (sof_seen < issued && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) check("timeout_issue", 1, 0);
        b = issued % 2;
        fill_buf(b);
        push_image(b);
        issued++;
        image_number = 4'(issued);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(eof_seen == issued && rd_image_number == 4'(issued) && !busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("timeout_done", 1, 0);
        check("exp_q_empty", exp_q.size(), 0);
        check("addr_q_empty", addr_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        image_number = 4'd0;
        issued = 0;
        sof_seen = 0;
        eof_seen = 0;
        beat_cnt = 0;
        exp_q.delete();
        addr_q.delete();
`ifdef BIT_PIX_RD_STALL_CNT_EN
        stall_m = 0;
`endif
        @(posedge clk);
        @(negedge clk);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_img", rd_image_number, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_en", bus.bram_rd_en, 0);
        check("rst_rd_addr", bus.bram_rd_addr, 0);
        check("rst_pix_out", bus.pix_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state and a single image with ready held high
        do_reset();
        low_pct = 0;
        issue_image();
        wait_done();
        check("img1_rd_img", rd_image_number, 1);
        check("beat_period", eof_cyc - sof_cyc, (BEATS - 1) * (4 + RD_LAT));
        check("img1_beats", beat_cnt, BEATS);

        // Back-to-back images alternate buffers
        issue_image();
        issue_image();
        wait_done();
        check("img3_rd_img", rd_image_number, 3);

        // Random backpressure across the 4-bit image count wrap
        low_pct = 30;
        for (int i = 0; i < 15; i++) issue_image();
        wait_done();
        check("wrap_rd_img", rd_image_number, 4'(18));
        check("no_overrun", overrun, 0);

        // Writer two images ahead
        low_pct = 0;
        do_reset();
        fill_buf(0);
        push_image(0);
        fill_buf(1);
        push_image(1);
        issued = 2;
        image_number = 4'd2;
        wait_done();
        check("overrun_set", overrun, 1);
        check("overrun_rd_img", rd_image_number, 2);

        // Reset in the middle of an image, then restart from buffer 0
        low_pct = 30;
        do_reset();
        issue_image();
        begin
            int n = 0;
            while (beat_cnt < 10 && n < 5000) begin @(negedge clk); n++; end
            if (n >= 5000) check("timeout_mid", 1, 0);
        end
        do_reset();
        issue_image();
        wait_done();
        check("restart_rd_img", rd_image_number, 1);
        check("restart_overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
